spi_flash_rd_seq: RTL and testbench

Read sequencer placed directly upstream of the x1spi single-line SPI flash controller. It accepts a read request (24-bit start address, 16-bit byte count) and splits it into bursts of at most BURST_LEN bytes. For each burst it drives one x1spi transaction (start/cmd/addr/dummy), collects returned bytes into an internal FIFO, and presents them on a valid/ready byte stream. A burst is issued only when the FIFO can absorb the whole burst, because x1spi cannot be back-pressured.

---
 rtl/spi_flash_rd_seq.sv | 205 ++++++++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq
//   Read sequencer sitting in front of the x1spi single-line SPI flash
//   controller. A read request (24-bit start address, 16-bit byte count) is
//   split into bursts of at most BURST_LEN bytes. Each burst is one x1spi
//   transaction. Returned bytes are collected in a first-word-fall-through
//   FIFO and presented as a valid/ready byte stream. A burst is issued only
//   when the FIFO has room for all of it, because x1spi cannot be stalled.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_addr, i_req_len   start byte address, byte count (0 = no-op)
//   o_busy                  request in progress
//   o_done                  one-cycle pulse once every requested byte is stored
//   o_dat_valid/o_dat       FIFO head byte, i_dat_ready pops it
//   o_spi_*                 x1spi command side (start pulse, opcode, address,
//                           dummy setting, "more bytes wanted")
//   i_spi_finish            x1spi transaction complete pulse
//   i_spi_data/i_spi_rdy    read byte from x1spi, one cycle per byte
module spi_flash_rd_seq #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter logic [7:0]  RD_CMD     = 8'h0B,
  parameter logic [2:0]  DUM_NUM    = 3'h3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  input  logic [15:0] i_req_len,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dat_valid,
  output logic [7:0]  o_dat,
  input  logic        i_dat_ready,
  output logic        o_spi_start,
  input  logic        i_spi_finish,
  output logic [7:0]  o_spi_cmd,
  output logic [23:0] o_spi_addr,
  output logic [2:0]  o_spi_dum_num,
  output logic        o_spi_exi_rdata,
  input  logic [7:0]  i_spi_data,
  input  logic        i_spi_rdy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BL = 16'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_ISSUE,
    S_RECV,
    S_WAIT_FIN
  } state_t;

  state_t      state, state_n;
  logic [23:0] cur_addr, cur_addr_n;
  logic [15:0] remaining, remaining_n;
  logic [15:0] rcv_cnt, rcv_cnt_n;
  logic [23:0] spi_addr, spi_addr_n;
  logic        exi, exi_n;
  logic        done, done_n;

  logic [15:0] blen;
  logic [15:0] rcvd;
  logic        push;
  logic        pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] fifo_free;

  // Burst length is derived from remaining, which only changes when a burst
  // ends, so it stays stable for the whole transaction.
  assign blen      = (remaining < BL) ? remaining : BL;
  assign push      = (state == S_RECV) && i_spi_rdy;
  assign rcvd      = rcv_cnt + 16'(push);
  assign pop       = (count != '0) && i_dat_ready;
  assign fifo_free = CW'(FIFO_DEPTH) - count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rcv_cnt   <= '0;
      spi_addr  <= '0;
      exi       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remaining <= remaining_n;
      rcv_cnt   <= rcv_cnt_n;
      spi_addr  <= spi_addr_n;
      exi       <= exi_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    rcv_cnt_n   = rcv_cnt;
    spi_addr_n  = spi_addr;
    exi_n       = exi;
    done_n      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_req_valid) begin
          cur_addr_n  = i_req_addr;
          remaining_n = i_req_len;
          if (i_req_len == '0) done_n  = 1'b1;
          else                 state_n = S_WAIT_ROOM;
        end
      end
      S_WAIT_ROOM: begin
        if (fifo_free >= CW'(blen)) begin
          state_n    = S_ISSUE;
          spi_addr_n = cur_addr;
          exi_n      = 1'b1;
          rcv_cnt_n  = '0;
        end
      end
      S_ISSUE: begin
        state_n   = S_RECV;
        rcv_cnt_n = '0;
      end
      S_RECV: begin
        rcv_cnt_n = rcvd;
        if (rcvd == blen) begin
          exi_n       = 1'b0;
          cur_addr_n  = cur_addr + 24'(blen);
          remaining_n = remaining - blen;
          // finish coinciding with the last byte skips WAIT_FIN
          if (i_spi_finish) begin
            if (remaining == blen) begin
              done_n  = 1'b1;
              state_n = S_IDLE;
            end else begin
              state_n = S_WAIT_ROOM;
            end
          end else begin
            state_n = S_WAIT_FIN;
          end
        end else if (i_spi_finish) begin
          // early termination: account only for bytes actually received and
          // re-issue from the first missing address
          exi_n       = 1'b0;
          cur_addr_n  = cur_addr + 24'(rcvd);
          remaining_n = remaining - rcvd;
          state_n     = S_WAIT_ROOM;
        end
      end
      S_WAIT_FIN: begin
        if (i_spi_finish) begin
          if (remaining == '0) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_ROOM;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_spi_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign o_req_ready     = (state == S_IDLE);
  assign o_busy          = (state != S_IDLE);
  assign o_done          = done;
  assign o_dat_valid     = (count != '0);
  assign o_dat           = (count != '0) ? mem[rd_ptr] : '0;
  assign o_spi_start     = (state == S_ISSUE);
  assign o_spi_cmd       = RD_CMD;
  assign o_spi_addr      = spi_addr;
  assign o_spi_dum_num   = DUM_NUM;
  assign o_spi_exi_rdata = exi;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
module tb_spi_flash_rd_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [23:0] i_req_addr = '0;
  logic [15:0] i_req_len = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_dat_valid;
  logic [7:0]  o_dat;
  logic        i_dat_ready = 1'b0;
  logic        o_spi_start;
  logic        i_spi_finish = 1'b0;
  logic [7:0]  o_spi_cmd;
  logic [23:0] o_spi_addr;
  logic [2:0]  o_spi_dum_num;
  logic        o_spi_exi_rdata;
  logic [7:0]  i_spi_data;
  logic        i_spi_rdy;

  logic       model_rdy = 1'b0;
  logic [7:0] model_data = '0;
  logic       stray_rdy = 1'b0;
  logic [7:0] stray_data = '0;
  assign i_spi_rdy  = model_rdy | stray_rdy;
  assign i_spi_data = model_rdy ? model_data : stray_data;

  spi_flash_rd_seq #(
    .BURST_LEN (16),
    .FIFO_DEPTH(32),
    .RD_CMD    (8'h0B),
    .DUM_NUM   (3'h3)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_len      (i_req_len),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_dat_valid    (o_dat_valid),
    .o_dat          (o_dat),
    .i_dat_ready    (i_dat_ready),
    .o_spi_start    (o_spi_start),
    .i_spi_finish   (i_spi_finish),
    .o_spi_cmd      (o_spi_cmd),
    .o_spi_addr     (o_spi_addr),
    .o_spi_dum_num  (o_spi_dum_num),
    .o_spi_exi_rdata(o_spi_exi_rdata),
    .i_spi_data     (i_spi_data),
    .i_spi_rdy      (i_spi_rdy)
  );

  always #5 i_clk = ~i_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Flash data as a function of byte address, so a wrong burst address shows
  // up as wrong data.
  function automatic logic [7:0] fdat(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  logic [7:0]  exp_q[$];
  logic [23:0] start_q[$];
  int          blen_q[$];
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          rx_cnt = 0;
  int          done_cyc = 0;
  int          fin_cyc = 0;
  int          early_stop = 0;

  // Monitor and consumer: sampled on the falling edge, a byte counts as taken
  // when valid & ready are both high ahead of the next rising edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_spi_start) begin
        start_cnt++;
        start_q.push_back(o_spi_addr);
      end
      if (o_dat_valid && i_dat_ready) begin
        if (exp_q.size() == 0) fail("extra_byte", {24'h0, o_dat}, 32'h0);
        else chk("byte", {24'h0, o_dat}, {24'h0, exp_q.pop_front()});
        rx_cnt++;
      end
    end
  end

  // x1spi model: after a start it returns one byte every other cycle while
  // exi_rdata stays high, then pulses finish. early_stop forces one truncated
  // transaction.
  initial begin
    logic [23:0] a;
    int          k;
    bit          aborted;
    forever begin
      @(posedge i_clk); #1;
      if (!i_rst && o_spi_start) begin
        a = o_spi_addr;
        k = 0;
        aborted = 1'b0;
        for (int n = 0; n < 300; n++) begin
          @(posedge i_clk); #1;
          if (i_rst) begin aborted = 1'b1; break; end
          model_rdy  = 1'b1;
          model_data = fdat(24'(a + 24'(k)));
          @(posedge i_clk); #1;
          model_rdy = 1'b0;
          k++;
          if (i_rst) begin aborted = 1'b1; break; end
          if (!o_spi_exi_rdata) break;
          if (early_stop != 0 && k == early_stop) begin
            early_stop = 0;
            break;
          end
        end
        if (!aborted) begin
          blen_q.push_back(k);
          i_spi_finish = 1'b1;
          fin_cyc = cyc;
          @(posedge i_clk); #1;
          i_spi_finish = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [23:0]       addr;
    logic [15:0]       len;
    int                es;
    int                nb;
    logic [2:0][23:0]  a;
    logic [2:0][8:0]   b;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] addr, input logic [15:0] len, input int es,
                              input int nb, input logic [23:0] a0, input logic [23:0] a1,
                              input logic [23:0] a2, input logic [8:0] b0, input logic [8:0] b1,
                              input logic [8:0] b2);
    vec_t v;
    v.addr = addr; v.len = len; v.es = es; v.nb = nb;
    v.a = {a2, a1, a0};
    v.b = {b2, b1, b0};
    return v;
  endfunction

  task automatic clear_obs();
    start_q.delete();
    blen_q.delete();
    exp_q.delete();
    start_cnt = 0;
    done_cnt  = 0;
    rx_cnt    = 0;
  endtask

  task automatic send_req(input logic [23:0] addr, input logic [15:0] len);
    int w;
    w = 0;
    while (!o_req_ready && w < 200) begin
      @(posedge i_clk); #1;
      w++;
    end
    chk("req_ready_wait", {31'h0, o_req_ready}, 32'h1);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(fdat(24'(addr + 24'(i))));
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_len   = len;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_complete(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (done_cnt >= 1 && exp_q.size() == 0 && !o_dat_valid && !o_busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    chk({name, "_complete"}, {31'h0, ok}, 32'h1);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    clear_obs();
    i_dat_ready = 1'b1;
    early_stop  = v.es;
    send_req(v.addr, v.len);
    wait_complete(nm);
    chk({nm, "_starts"}, start_cnt, v.nb);
    for (int i = 0; i < v.nb; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), (i < start_q.size()) ? {8'h0, start_q[i]} : 32'hDEAD_BEEF,
          {8'h0, v.a[i]});
      chk($sformatf("%s_blen%0d", nm, i), (i < blen_q.size()) ? blen_q[i] : -1, {23'h0, v.b[i]});
    end
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_bytes"}, rx_cnt, {16'h0, v.len});
    if (v.len != 0) chk({nm, "_done_lat"}, done_cyc, fin_cyc + 1);
  endtask

  vec_t vecs[6];

  initial begin
    int w;
    vecs[0] = mk(24'h555555, 16'd3,  0, 1, 24'h555555, 24'h0,     24'h0,     9'd3,  9'd0,  9'd0);
    vecs[1] = mk(24'h000100, 16'd40, 0, 3, 24'h000100, 24'h000110, 24'h000120, 9'd16, 9'd16, 9'd8);
    vecs[2] = mk(24'hFFFFF8, 16'd32, 0, 2, 24'hFFFFF8, 24'h000008, 24'h0,     9'd16, 9'd16, 9'd0);
    vecs[3] = mk(24'h000000, 16'd0,  0, 0, 24'h0,      24'h0,     24'h0,     9'd0,  9'd0,  9'd0);
    vecs[4] = mk(24'hABCDEF, 16'd17, 0, 2, 24'hABCDEF, 24'hABCDFF, 24'h0,     9'd16, 9'd1,  9'd0);
    vecs[5] = mk(24'h000300, 16'd16, 5, 2, 24'h000300, 24'h000305, 24'h0,     9'd5,  9'd11, 9'd0);

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    chk("rst_start", {31'h0, o_spi_start}, 32'h0);
    chk("rst_exi", {31'h0, o_spi_exi_rdata}, 32'h0);
    chk("rst_addr", {8'h0, o_spi_addr}, 32'h0);
    chk("rst_dat_valid", {31'h0, o_dat_valid}, 32'h0);
    chk("rst_dat", {24'h0, o_dat}, 32'h0);
    chk("cmd", {24'h0, o_spi_cmd}, 32'h0B);
    chk("dum", {29'h0, o_spi_dum_num}, 32'h3);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      if (vecs[i].len == 0) begin
        // stray byte while idle must not reach the FIFO
        stray_rdy  = 1'b1;
        stray_data = 8'hEE;
        @(posedge i_clk); #1;
        stray_rdy = 1'b0;
        @(posedge i_clk); #1;
        chk("stray_dat_valid", {31'h0, o_dat_valid}, 32'h0);
        chk("len0_no_start", start_cnt, 0);
      end
    end

    // consumer stalled: two bursts fill the FIFO, third waits for room
    clear_obs();
    i_dat_ready = 1'b0;
    send_req(24'h000200, 16'd48);
    w = 0;
    while (start_cnt < 2 && w < 500) begin
      @(posedge i_clk); #1;
      w++;
    end
    repeat (150) @(posedge i_clk);
    #1;
    chk("bp_starts", start_cnt, 2);
    chk("bp_dat_valid", {31'h0, o_dat_valid}, 32'h1);
    chk("bp_head", {24'h0, o_dat}, {24'h0, fdat(24'h000200)});
    chk("bp_busy", {31'h0, o_busy}, 32'h1);
    chk("bp_done", done_cnt, 0);
    i_dat_ready = 1'b1;
    wait_complete("bp");
    chk("bp_starts_end", start_cnt, 3);
    chk("bp_addr2", (start_q.size() > 2) ? {8'h0, start_q[2]} : 32'hDEAD_BEEF, 32'h000220);
    chk("bp_bytes", rx_cnt, 48);
    chk("bp_done_end", done_cnt, 1);

    // reset in the middle of a burst
    clear_obs();
    i_dat_ready = 1'b0;
    send_req(24'h000400, 16'd16);
    w = 0;
    while (start_cnt < 1 && w < 200) begin
      @(posedge i_clk); #1;
      w++;
    end
    repeat (7) @(posedge i_clk);
    #1;
    chk("mid_in_recv", {31'h0, o_spi_exi_rdata & o_dat_valid}, 32'h1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'h0, o_req_ready}, 32'h1);
    chk("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    chk("mid_rst_exi", {31'h0, o_spi_exi_rdata}, 32'h0);
    chk("mid_rst_addr", {8'h0, o_spi_addr}, 32'h0);
    chk("mid_rst_dat_valid", {31'h0, o_dat_valid}, 32'h0);
    chk("mid_rst_dat", {24'h0, o_dat}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_idle", {31'h0, o_busy}, 32'h0);
    run_vec(vecs[1], 6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
